// File: rtl/dom_mul_gf2_sched.sv
// ============================================================================
// Module   : dom_mul_gf2_sched
// Purpose  : Shares one pipelined DOM GF(2^2) multiplier between NREQ
//            requesters. It arbitrates round-robin, pairs each issue with
//            fresh randomness, tags it through the multiplier latency and
//            returns the product shares to the requester that issued it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dom_mul_gf2_sched #(
  parameter int SHARES = 2,
  parameter int NREQ   = 2,
  parameter int LAT    = 1
) (
  input  logic                         ClkxCI,
  input  logic                         RstxRI,
  input  logic [NREQ-1:0]              ReqValidxSI,
  output logic [NREQ-1:0]              ReqReadyxSO,
  input  logic [NREQ*2*SHARES-1:0]     ReqXxDI,
  input  logic [NREQ*2*SHARES-1:0]     ReqYxDI,
  input  logic                         RandValidxSI,
  output logic                         RandReadyxSO,
  input  logic [SHARES*(SHARES-1)-1:0] RandZxDI,
  output logic [2*SHARES-1:0]          MulXxDO,
  output logic [2*SHARES-1:0]          MulYxDO,
  output logic [SHARES*(SHARES-1)-1:0] MulZxDO,
  output logic [2*SHARES-1:0]          MulBxDO,
  input  logic [2*SHARES-1:0]          MulQxDI,
  output logic [NREQ-1:0]              RspValidxSO,
  output logic [2*SHARES-1:0]          RspQxDO,
  output logic                         BusyxSO
);

  localparam int SW = 2 * SHARES;
  localparam int ZW = SHARES * (SHARES - 1);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0] C_NREQ = (PW + 1)'(NREQ);
  localparam logic [PW:0] C_ONE  = (PW + 1)'(1);

  // Round-robin pointer
  logic [PW-1:0]          ptr_q;
  logic [PW-1:0]          ptr_d;
  logic [PW:0]            ptr_inc;

  // Arbitration
  logic [PW-1:0]          grant;
  logic [PW:0]            arb_idx;
  logic                   arb_found;
  logic                   any_req;
  logic                   issue;
  logic [NREQ-1:0]        grant_oh;

  // Granted operands
  logic [SW-1:0]          sel_x;
  logic [SW-1:0]          sel_y;

  // Multiplier-facing operand registers
  logic [SW-1:0]          mul_x_q;
  logic [SW-1:0]          mul_y_q;
  logic [ZW-1:0]          mul_z_q;

  // Tag pipeline: entry 0 written at issue, entry LAT aligned with MulQxDI
  logic [LAT:0]           tag_vld_q;
  logic [LAT:0][NREQ-1:0] tag_id_q;

  // Response registers
  logic [NREQ-1:0]        rsp_vld_q;
  logic [SW-1:0]          rsp_q_q;

  assign any_req = |ReqValidxSI;
  assign issue   = RandValidxSI & any_req & ~RstxRI;

  // Pick the first valid requester starting at the pointer, wrapping mod NREQ
  always_comb begin
    grant     = ptr_q;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      arb_idx = {1'b0, ptr_q} + (PW + 1)'(k);
      if (arb_idx >= C_NREQ) begin
        arb_idx = arb_idx - C_NREQ;
      end
      if (!arb_found && ReqValidxSI[arb_idx[PW-1:0]]) begin
        grant     = arb_idx[PW-1:0];
        arb_found = 1'b1;
      end
    end
  end

  // One-hot grant, only asserted when the issue actually happens
  always_comb begin
    grant_oh = '0;
    if (issue) begin
      grant_oh[grant] = 1'b1;
    end
  end

  // Pointer moves just past the granted requester on issue, holds otherwise
  always_comb begin
    ptr_inc = {1'b0, grant} + C_ONE;
    ptr_d   = ptr_q;
    if (issue) begin
      ptr_d = (ptr_inc == C_NREQ) ? '0 : ptr_inc[PW-1:0];
    end
  end

  assign sel_x = ReqXxDI[int'(grant) * SW +: SW];
  assign sel_y = ReqYxDI[int'(grant) * SW +: SW];

  assign ReqReadyxSO  = grant_oh;
  assign RandReadyxSO = issue;

  // Operand, tag and response registers; idle cycles flush operands to zero
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      ptr_q     <= '0;
      mul_x_q   <= '0;
      mul_y_q   <= '0;
      mul_z_q   <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      rsp_vld_q <= '0;
      rsp_q_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      mul_x_q      <= issue ? sel_x : '0;
      mul_y_q      <= issue ? sel_y : '0;
      mul_z_q      <= issue ? RandZxDI : '0;
      tag_vld_q[0] <= issue;
      tag_id_q[0]  <= grant_oh;
      for (int i = 1; i <= LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      rsp_vld_q <= tag_vld_q[LAT] ? tag_id_q[LAT] : '0;
      rsp_q_q   <= tag_vld_q[LAT] ? MulQxDI : '0;
    end
  end

  assign MulXxDO     = mul_x_q;
  assign MulYxDO     = mul_y_q;
  assign MulZxDO     = mul_z_q;
  assign MulBxDO     = '0;
  assign RspValidxSO = rsp_vld_q;
  assign RspQxDO     = rsp_q_q;
  assign BusyxSO     = (|tag_vld_q) | (|rsp_vld_q);

endmodule

`default_nettype wire

// File: tb/tb_dom_mul_gf2_sched.sv
// ============================================================================
// Module   : tb_dom_mul_gf2_sched
// Purpose  : Directed bench for dom_mul_gf2_sched with two instances
//            (SHARES=3/NREQ=2 and SHARES=2/NREQ=4) and stub multipliers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dom_mul_gf2_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: SHARES=3, NREQ=2, LAT=1
  logic [1:0]  r2_v;
  logic [11:0] r2_x, r2_y;
  logic        r2_rv;
  logic [5:0]  r2_z;
  logic [1:0]  r2_rdy;
  logic        r2_rrdy;
  logic [5:0]  m2_x, m2_y, m2_z, m2_b, m2_q;
  logic [1:0]  r2_rsp;
  logic [5:0]  r2_rq;
  logic        r2_busy;

  // Instance B: SHARES=2, NREQ=4, LAT=1
  logic [3:0]  r4_v;
  logic [15:0] r4_x, r4_y;
  logic        r4_rv;
  logic [1:0]  r4_z;
  logic [3:0]  r4_rdy;
  logic        r4_rrdy;
  logic [3:0]  m4_x, m4_y, m4_b, m4_q;
  logic [1:0]  m4_z;
  logic [3:0]  r4_rsp;
  logic [3:0]  r4_rq;
  logic        r4_busy;

  // 0: stub returns X unchanged, 1: unmasked reference GF(2^2) product
  logic mode;

  int n_run  = 0;
  int n_fail = 0;

  dom_mul_gf2_sched #(.SHARES(3), .NREQ(2), .LAT(1)) dut2 (
    .ClkxCI(clk), .RstxRI(rst),
    .ReqValidxSI(r2_v), .ReqReadyxSO(r2_rdy),
    .ReqXxDI(r2_x), .ReqYxDI(r2_y),
    .RandValidxSI(r2_rv), .RandReadyxSO(r2_rrdy), .RandZxDI(r2_z),
    .MulXxDO(m2_x), .MulYxDO(m2_y), .MulZxDO(m2_z), .MulBxDO(m2_b),
    .MulQxDI(m2_q),
    .RspValidxSO(r2_rsp), .RspQxDO(r2_rq), .BusyxSO(r2_busy)
  );

  dom_mul_gf2_sched #(.SHARES(2), .NREQ(4), .LAT(1)) dut4 (
    .ClkxCI(clk), .RstxRI(rst),
    .ReqValidxSI(r4_v), .ReqReadyxSO(r4_rdy),
    .ReqXxDI(r4_x), .ReqYxDI(r4_y),
    .RandValidxSI(r4_rv), .RandReadyxSO(r4_rrdy), .RandZxDI(r4_z),
    .MulXxDO(m4_x), .MulYxDO(m4_y), .MulZxDO(m4_z), .MulBxDO(m4_b),
    .MulQxDI(m4_q),
    .RspValidxSO(r4_rsp), .RspQxDO(r4_rq), .BusyxSO(r4_busy)
  );

  function automatic logic [1:0] xr3(input logic [5:0] v);
    return v[1:0] ^ v[3:2] ^ v[5:4];
  endfunction

  function automatic logic [1:0] gf4(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] p;
    p[1] = (a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]);
    p[0] = (a[1] & b[1]) ^ (a[0] & b[0]);
    return p;
  endfunction

  function automatic logic [5:0] ref_mul(input logic [5:0] x, input logic [5:0] y,
                                         input logic [5:0] z);
    logic [1:0] p;
    p = gf4(xr3(x), xr3(y));
    return {2'b00, z[1:0], p ^ z[1:0]};
  endfunction

  // One-cycle stub multipliers
  always @(posedge clk) begin
    m2_q <= mode ? ref_mul(m2_x, m2_y, m2_z) : m2_x;
    m4_q <= m4_x;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [11:0] x;
    logic [11:0] y;
    logic [5:0]  z;
    logic [1:0]  rdy;
    logic [5:0]  mx;
    logic [1:0]  prod;
  } vec_t;

  vec_t tv [6];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] e2;
    logic [5:0] eq;

    // pointer starts at 0 and is tracked by hand in the rdy column
    tv[0] = '{2'b01, 12'h002, 12'h000, 6'h2A, 2'b01, 6'h02, 2'd0};
    tv[1] = '{2'b11, 12'h1BF, 12'h0C1, 6'h33, 2'b10, 6'h06, 2'd2};
    tv[2] = '{2'b11, 12'h1BF, 12'h0C1, 6'h15, 2'b01, 6'h3F, 2'd3};
    tv[3] = '{2'b01, 12'h025, 12'h003, 6'h0C, 2'b01, 6'h25, 2'd1};
    tv[4] = '{2'b10, 12'h080, 12'h080, 6'h21, 2'b10, 6'h02, 2'd3};
    tv[5] = '{2'b00, 12'h0FF, 12'h0FF, 6'h3F, 2'b00, 6'h00, 2'd0};

    mode = 1'b1;
    rst  = 1'b1;
    r2_v = 2'b11; r2_x = '0; r2_y = '0; r2_rv = 1'b1; r2_z = '0;
    r4_v = 4'hF;  r4_x = '0; r4_y = '0; r4_rv = 1'b1; r4_z = '0;

    // Ready must stay low while reset is asserted
    cyc; cyc;
    @(negedge clk);
    chk("rst_ready2", 32'(r2_rdy), 32'h0);
    chk("rst_randready2", 32'(r2_rrdy), 32'h0);
    chk("rst_ready4", 32'(r4_rdy), 32'h0);
    cyc;
    rst = 1'b0;
    r2_v = '0; r2_rv = 1'b0; r4_v = '0; r4_rv = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_rsp", 32'(r2_rsp), 32'h0);
      chk("idle_rq", 32'(r2_rq), 32'h0);
      chk("idle_mulx", 32'(m2_x), 32'h0);
      chk("idle_mulz", 32'(m2_z), 32'h0);
      chk("idle_busy", 32'(r2_busy), 32'h0);
      chk("idle_ready", 32'({r2_rdy, r2_rrdy}), 32'h0);
      chk("idle_busy4", 32'(r4_busy), 32'h0);
      cyc;
    end
    chk("mulb_zero", 32'({m2_b, m4_b}), 32'h0);

    // Table of single issues through the reference multiplier
    for (int i = 0; i < 6; i++) begin
      r2_v = tv[i].req; r2_x = tv[i].x; r2_y = tv[i].y; r2_z = tv[i].z; r2_rv = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(r2_rdy), 32'(tv[i].rdy));
      chk($sformatf("v%0d_randready", i), 32'(r2_rrdy), 32'(tv[i].rdy != 2'b00));
      cyc;
      r2_v = '0; r2_rv = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_mulz", i), 32'(m2_z), (tv[i].rdy != 2'b00) ? 32'(tv[i].z) : 32'h0);
      chk($sformatf("v%0d_mulx", i), 32'(m2_x), 32'(tv[i].mx));
      chk($sformatf("v%0d_busy", i), 32'(r2_busy), 32'(tv[i].rdy != 2'b00));
      cyc;
      @(negedge clk);
      chk($sformatf("v%0d_rsp_early", i), 32'(r2_rsp), 32'h0);
      cyc;
      @(negedge clk);
      chk($sformatf("v%0d_rsp", i), 32'(r2_rsp), 32'(tv[i].rdy));
      chk($sformatf("v%0d_prod", i), 32'(xr3(r2_rq)), 32'(tv[i].prod));
      cyc;
      @(negedge clk);
      chk($sformatf("v%0d_busy_end", i), 32'(r2_busy), 32'h0);
      cyc;
    end

    // Both requesters continuously valid: alternating grants, 3-cycle responses
    mode = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        r2_v = 2'b11; r2_rv = 1'b1; r2_x = {6'h2A, 6'h15}; r2_z = 6'(c);
      end else begin
        r2_v = '0; r2_rv = 1'b0;
      end
      @(negedge clk);
      e2 = (c < 4) ? ((c % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk($sformatf("alt%0d_ready", c), 32'(r2_rdy), 32'(e2));
      if (c >= 3 && c < 7) begin
        e2 = ((c - 3) % 2 == 1) ? 2'b10 : 2'b01;
        eq = ((c - 3) % 2 == 1) ? 6'h2A : 6'h15;
      end else begin
        e2 = 2'b00;
        eq = 6'h00;
      end
      chk($sformatf("alt%0d_rsp", c), 32'(r2_rsp), 32'(e2));
      chk($sformatf("alt%0d_rq", c), 32'(r2_rq), 32'(eq));
      cyc;
    end

    // Randomness stall: pointer holds, then grants the pointer's requester
    r2_v = 2'b01; r2_rv = 1'b1; r2_x = {6'h00, 6'h07};
    @(negedge clk);
    chk("stall_pre_ready", 32'(r2_rdy), 32'h1);
    cyc;
    r2_v = 2'b11; r2_rv = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_ready", c), 32'({r2_rdy, r2_rrdy}), 32'h0);
      cyc;
    end
    r2_rv = 1'b1;
    @(negedge clk);
    chk("stall_post_ready", 32'(r2_rdy), 32'h2);
    cyc;
    r2_v = '0; r2_rv = 1'b0;
    cyc; cyc;
    @(negedge clk);
    chk("stall_post_rsp", 32'(r2_rsp), 32'h2);
    cyc; cyc;

    // Reset in flight discards pending responses and resets the pointer
    for (int c = 0; c < 3; c++) begin
      r2_v = 2'b11; r2_rv = 1'b1; r2_x = {6'h2A, 6'h15};
      @(negedge clk);
      chk($sformatf("rstmid%0d_ready", c), 32'(r2_rdy), (c % 2 == 1) ? 32'h2 : 32'h1);
      cyc;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_ready_in_rst", 32'({r2_rdy, r2_rrdy}), 32'h0);
    chk("rstmid_first_rsp", 32'(r2_rsp), 32'h1);
    cyc;
    rst = 1'b0; r2_v = '0; r2_rv = 1'b0;
    @(negedge clk);
    chk("rstmid_rsp", 32'(r2_rsp), 32'h0);
    chk("rstmid_mulx", 32'(m2_x), 32'h0);
    chk("rstmid_busy", 32'(r2_busy), 32'h0);
    cyc;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid_late%0d_rsp", c), 32'(r2_rsp), 32'h0);
      cyc;
    end
    r2_v = 2'b11; r2_rv = 1'b1;
    @(negedge clk);
    chk("rstmid_ptr_reset", 32'(r2_rdy), 32'h1);
    cyc;
    r2_v = '0; r2_rv = 1'b0;
    repeat (4) cyc;

    // NREQ=4: only requester 2 valid for 3 cycles
    r4_rv = 1'b1;
    for (int c = 0; c < 3; c++) begin
      r4_v = 4'b0100;
      r4_x = {4'h0, 4'(c + 1), 8'h00};
      @(negedge clk);
      chk($sformatf("n4_%0d_ready", c), 32'(r4_rdy), 32'h4);
      cyc;
    end
    r4_v = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("n4_%0d_rsp", c), 32'(r4_rsp), 32'h4);
      chk($sformatf("n4_%0d_rq", c), 32'(r4_rq), 32'(c + 1));
      cyc;
    end
    r4_v = 4'hF;
    @(negedge clk);
    chk("n4_ptr3", 32'(r4_rdy), 32'h8);
    chk("n4_rsp_done", 32'(r4_rsp), 32'h0);
    cyc;
    r4_v = '0; r4_rv = 1'b0;
    repeat (4) cyc;
    @(negedge clk);
    chk("n4_busy_end", 32'(r4_busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
